// File: rtl/biriscv_lat_mem_model_if.sv
// Core-side memory bus for biriscv_lat_mem_model: split fetch and data channels plus interrupt level.
interface biriscv_lat_mem_model_if #(
  parameter int unsigned TAG_W = 11
);
  logic              imem_rd;
  logic [31:0]       imem_pc;
  logic              imem_flush;
  logic              imem_accept;
  logic              imem_valid;
  logic [63:0]       imem_data;
  logic              imem_error;
  logic [31:0]       dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_rd;
  logic [3:0]        dmem_wr;
  logic [TAG_W-1:0]  dmem_req_tag;
  logic              dmem_accept;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  logic [TAG_W-1:0]  dmem_resp_tag;
  logic              dmem_error;
  logic              intr_o;

  modport master (
    output imem_rd, imem_pc, imem_flush,
    output dmem_addr, dmem_wdata, dmem_rd, dmem_wr, dmem_req_tag,
    input  imem_accept, imem_valid, imem_data, imem_error,
    input  dmem_accept, dmem_ack, dmem_rdata, dmem_resp_tag, dmem_error, intr_o
  );

  modport slave (
    input  imem_rd, imem_pc, imem_flush,
    input  dmem_addr, dmem_wdata, dmem_rd, dmem_wr, dmem_req_tag,
    output imem_accept, imem_valid, imem_data, imem_error,
    output dmem_accept, dmem_ack, dmem_rdata, dmem_resp_tag, dmem_error, intr_o
  );
endinterface

// File: rtl/biriscv_lat_mem_model.sv
// Shared I/D memory model: pipelined fetch, tagged in-order data queue with fixed latency,
// LFSR accept backpressure, out-of-range errors and an MMIO interrupt register.
module biriscv_lat_mem_model #(
  parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
  parameter int unsigned MEM_WORDS_W  = 14,
  parameter int unsigned IMEM_LATENCY = 1,
  parameter int unsigned DMEM_LATENCY = 2,
  parameter int unsigned DMEM_DEPTH   = 4,
  parameter int unsigned DMEM_DEPTH_W = 2,
  parameter int unsigned TAG_W        = 11,
  parameter bit          STALL_ENABLE = 1'b1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [31:0] INTR_ADDR    = 32'h9000_0000
) (
  input logic                     clk,
  input logic                     rst,
  biriscv_lat_mem_model_if.slave  bus
);

  localparam int unsigned RAM_DEPTH = 1 << MEM_WORDS_W;
  localparam int unsigned AGE_W     = $clog2(DMEM_LATENCY + 1);
  localparam logic [AGE_W-1:0]        AGE_MAX = AGE_W'(DMEM_LATENCY);
  localparam logic [DMEM_DEPTH_W:0]   CNT_MAX = (DMEM_DEPTH_W + 1)'(DMEM_DEPTH);

  function automatic logic in_range(input logic [31:0] a);
    return a[31:MEM_WORDS_W+2] == MEM_BASE[31:MEM_WORDS_W+2];
  endfunction

  logic [31:0] ram [RAM_DEPTH];
  logic [15:0] lfsr;
  logic        stall_i, stall_d;
  logic        intr_q;

  assign stall_i = STALL_ENABLE && (lfsr[3:2] == 2'b00);
  assign stall_d = STALL_ENABLE && (lfsr[1:0] == 2'b00);

  // ---------------- fetch side ----------------
  logic                   i_hit, i_fire;
  logic [MEM_WORDS_W-2:0] i_line;
  logic [63:0]            i_word;
  logic                   i_vld [IMEM_LATENCY];
  logic [63:0]            i_dat [IMEM_LATENCY];
  logic                   i_err [IMEM_LATENCY];
  logic                   unused_ok;

  assign unused_ok = ^bus.imem_pc[2:0];
  assign i_hit     = in_range(bus.imem_pc);
  assign i_line    = bus.imem_pc[MEM_WORDS_W+1:3];
  assign i_word    = i_hit ? {ram[{i_line, 1'b1}], ram[{i_line, 1'b0}]} : '0;
  assign bus.imem_accept = !rst && !stall_i;
  assign i_fire    = bus.imem_rd && bus.imem_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < IMEM_LATENCY; k++) begin
        i_vld[k] <= 1'b0;
        i_dat[k] <= '0;
        i_err[k] <= 1'b0;
      end
    end else begin
      for (int unsigned k = IMEM_LATENCY - 1; k > 0; k--) begin
        i_vld[k] <= i_vld[k-1];
        i_dat[k] <= i_dat[k-1];
        i_err[k] <= i_err[k-1];
      end
      i_vld[0] <= i_fire;
      i_dat[0] <= i_fire ? i_word : '0;
      i_err[0] <= i_fire && !i_hit;
      // flush also kills the fetch being accepted at this same edge
      if (bus.imem_flush) begin
        for (int unsigned k = 0; k < IMEM_LATENCY; k++) i_vld[k] <= 1'b0;
      end
    end
  end

  assign bus.imem_valid = i_vld[IMEM_LATENCY-1];
  assign bus.imem_data  = i_vld[IMEM_LATENCY-1] ? i_dat[IMEM_LATENCY-1] : '0;
  assign bus.imem_error = i_vld[IMEM_LATENCY-1] && i_err[IMEM_LATENCY-1];

  // ---------------- data side ----------------
  logic                   d_req, d_wr_any, d_mmio, d_hit, d_push, d_pop, d_full;
  logic [MEM_WORDS_W-1:0] d_idx;
  logic [31:0]            d_rdata;
  logic                   d_err;
  logic [DMEM_DEPTH_W:0]  count;
  logic [DMEM_DEPTH_W-1:0] rd_ptr, wr_ptr;
  logic [TAG_W-1:0]       q_tag   [DMEM_DEPTH];
  logic [31:0]            q_rdata [DMEM_DEPTH];
  logic                   q_err   [DMEM_DEPTH];
  logic [AGE_W-1:0]       q_age   [DMEM_DEPTH];

  assign d_wr_any = |bus.dmem_wr;
  assign d_req    = bus.dmem_rd || d_wr_any;
  assign d_mmio   = bus.dmem_addr == INTR_ADDR;
  assign d_hit    = in_range(bus.dmem_addr) && !d_mmio;
  assign d_idx    = bus.dmem_addr[MEM_WORDS_W+1:2];
  assign d_full   = count == CNT_MAX;
  assign d_pop    = (count != '0) && (q_age[rd_ptr] == AGE_MAX);
  assign bus.dmem_accept = !rst && !stall_d && (!d_full || d_pop);
  assign d_push   = d_req && bus.dmem_accept;

  always_comb begin
    d_rdata = '0;
    d_err   = (bus.dmem_rd && d_wr_any) || (!d_mmio && !d_hit);
    if (bus.dmem_rd && !d_wr_any) begin
      if (d_mmio)     d_rdata = {31'b0, intr_q};
      else if (d_hit) d_rdata = ram[d_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (d_push && d_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.dmem_wr[b]) ram[d_idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
      end
    end
  end

  // Payload needs no reset: count gates every use of a slot.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DMEM_DEPTH; k++) begin
      if (q_age[k] != AGE_MAX) q_age[k] <= q_age[k] + AGE_W'(1);
    end
    if (d_push) begin
      q_tag[wr_ptr]   <= bus.dmem_req_tag;
      q_rdata[wr_ptr] <= d_rdata;
      q_err[wr_ptr]   <= d_err;
      q_age[wr_ptr]   <= AGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      lfsr   <= LFSR_SEED;
      intr_q <= 1'b0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (d_push) wr_ptr <= wr_ptr + DMEM_DEPTH_W'(1);
      if (d_pop)  rd_ptr <= rd_ptr + DMEM_DEPTH_W'(1);
      case ({d_push, d_pop})
        2'b10:   count <= count + (DMEM_DEPTH_W + 1)'(1);
        2'b01:   count <= count - (DMEM_DEPTH_W + 1)'(1);
        default: count <= count;
      endcase
      if (d_push && d_mmio && bus.dmem_wr[0]) intr_q <= bus.dmem_wdata[0];
    end
  end

  assign bus.dmem_ack      = d_pop;
  assign bus.dmem_resp_tag = d_pop ? q_tag[rd_ptr]   : '0;
  assign bus.dmem_rdata    = d_pop ? q_rdata[rd_ptr] : '0;
  assign bus.dmem_error    = d_pop && q_err[rd_ptr];
  assign bus.intr_o        = intr_q;

endmodule

// File: tb/tb_biriscv_lat_mem_model.sv
// Scoreboard bench for biriscv_lat_mem_model: directed requests push expected responses,
// a negedge monitor pops and compares every ack/valid, including its cycle of arrival.
`timescale 1ns/1ps
module tb_biriscv_lat_mem_model;

  typedef struct {
    logic [10:0] tag;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } dexp_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } iexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ivalid_seen = 0;
  int   dack2_seen = 0;
  dexp_t dq1[$];
  dexp_t dq2[$];
  iexp_t iq[$];

  localparam logic [31:0] INTR = 32'h9000_0000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  biriscv_lat_mem_model_if #(.TAG_W(11)) bus1 ();
  biriscv_lat_mem_model_if #(.TAG_W(11)) bus2 ();

  biriscv_lat_mem_model #(.IMEM_LATENCY(2), .DMEM_LATENCY(2), .STALL_ENABLE(1'b0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  biriscv_lat_mem_model #(.IMEM_LATENCY(1), .DMEM_LATENCY(6), .STALL_ENABLE(1'b0)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    dexp_t de;
    iexp_t ie;
    if (bus1.dmem_ack) begin
      if (dq1.size() == 0) begin
        chk("dack1_unexpected", 64'(bus1.dmem_resp_tag), 64'h7FF0_0000);
      end else begin
        de = dq1.pop_front();
        chk("dack1_tag",   64'(bus1.dmem_resp_tag), 64'(de.tag));
        chk("dack1_rdata", 64'(bus1.dmem_rdata),    64'(de.rdata));
        chk("dack1_err",   64'(bus1.dmem_error),    64'(de.err));
        chk("dack1_cyc",   64'(cyc),                64'(de.cyc));
      end
    end
    if (bus1.imem_valid) begin
      ivalid_seen++;
      if (iq.size() == 0) begin
        chk("ivalid_unexpected", bus1.imem_data, 64'hFFFF_FFFF_0000_0000);
      end else begin
        ie = iq.pop_front();
        chk("ival_data", bus1.imem_data,        ie.data);
        chk("ival_err",  64'(bus1.imem_error),  64'(ie.err));
        chk("ival_cyc",  64'(cyc),              64'(ie.cyc));
      end
    end
    if (bus2.dmem_ack) begin
      dack2_seen++;
      if (dq2.size() == 0) begin
        chk("dack2_unexpected", 64'(bus2.dmem_resp_tag), 64'h7FF0_0000);
      end else begin
        de = dq2.pop_front();
        chk("dack2_tag",   64'(bus2.dmem_resp_tag), 64'(de.tag));
        chk("dack2_rdata", 64'(bus2.dmem_rdata),    64'(de.rdata));
        chk("dack2_err",   64'(bus2.dmem_error),    64'(de.err));
        chk("dack2_cyc",   64'(cyc),                64'(de.cyc));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic d1(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                    input logic [3:0] wr, input logic [10:0] tag,
                    input logic [31:0] exp_rd, input logic exp_err);
    dexp_t e;
    bit ok = 1'b0;
    bus1.dmem_addr = a; bus1.dmem_wdata = wd; bus1.dmem_rd = rd;
    bus1.dmem_wr = wr; bus1.dmem_req_tag = tag;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus1.dmem_accept) begin
        e.tag = tag; e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + 2;
        dq1.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("d1_accept_timeout", 64'(tag), 64'h7FF0_0000);
    bus1.dmem_rd = 1'b0; bus1.dmem_wr = '0;
  endtask

  task automatic f1(input logic [31:0] pc, input logic [63:0] exp_data, input logic exp_err);
    iexp_t e;
    bit ok = 1'b0;
    bus1.imem_pc = pc; bus1.imem_rd = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus1.imem_accept) begin
        e.data = exp_data; e.err = exp_err; e.cyc = cyc + 2;
        iq.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("f1_accept_timeout", 64'(pc), 64'hFFFF_FFFF_0000_0000);
    bus1.imem_rd = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (dq1.size() + dq2.size() + iq.size()) != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_pending", 64'(dq1.size() + dq2.size() + iq.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    dexp_t e;
    int seen;
    int idx;
    logic [7:0] exp_acc;

    bus1.imem_rd = 1'b0; bus1.imem_pc = '0; bus1.imem_flush = 1'b0;
    bus1.dmem_addr = '0; bus1.dmem_wdata = '0; bus1.dmem_rd = 1'b0;
    bus1.dmem_wr = '0; bus1.dmem_req_tag = '0;
    bus2.imem_rd = 1'b0; bus2.imem_pc = '0; bus2.imem_flush = 1'b0;
    bus2.dmem_addr = '0; bus2.dmem_wdata = '0; bus2.dmem_rd = 1'b0;
    bus2.dmem_wr = '0; bus2.dmem_req_tag = '0;

    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_imem_accept", 64'(bus1.imem_accept), 64'd0);
    chk("rst_dmem_accept", 64'(bus1.dmem_accept), 64'd0);
    chk("rst_dmem_ack",    64'(bus1.dmem_ack),    64'd0);
    chk("rst_imem_valid",  64'(bus1.imem_valid),  64'd0);
    chk("rst_intr",        64'(bus1.intr_o),      64'd0);
    chk("rst_d2_accept",   64'(bus2.dmem_accept), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_daccept", 64'(bus1.dmem_accept), 64'd1);
    chk("post_rst_iaccept", 64'(bus1.imem_accept), 64'd1);
    @(posedge clk); #1;

    // write/read ordering, byte enables, rd+wr error, window edges
    d1(32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 4'hF, 11'd5,  32'h0,         1'b0);
    d1(32'h8000_0010, 32'h0,         1'b1, 4'h0, 11'd6,  32'hDEAD_BEEF, 1'b0);
    d1(32'h8000_0014, 32'h1122_3344, 1'b0, 4'hF, 11'd7,  32'h0,         1'b0);
    d1(32'h8000_0014, 32'h0000_AA00, 1'b0, 4'h2, 11'd8,  32'h0,         1'b0);
    d1(32'h8000_0014, 32'h0,         1'b1, 4'h0, 11'd9,  32'h1122_AA44, 1'b0);
    d1(32'h8000_0018, 32'h0000_0055, 1'b1, 4'hF, 11'd10, 32'h0,         1'b1);
    d1(32'h8000_0018, 32'h0,         1'b1, 4'h0, 11'd11, 32'h0000_0055, 1'b0);
    d1(32'h8000_001C, 32'h0BAD_C0DE, 1'b0, 4'hF, 11'd12, 32'h0,         1'b0);
    d1(32'h8000_0000, 32'hCAFE_F00D, 1'b0, 4'hF, 11'd13, 32'h0,         1'b0);
    d1(32'h8000_0004, 32'h0102_0304, 1'b0, 4'hF, 11'd14, 32'h0,         1'b0);
    d1(32'h8000_FFFC, 32'hA5A5_A5A5, 1'b0, 4'hF, 11'd15, 32'h0,         1'b0);
    d1(32'h8000_FFFC, 32'h0,         1'b1, 4'h0, 11'd16, 32'hA5A5_A5A5, 1'b0);

    // out of range: error, no side effect (0x80010000 would alias word 0)
    d1(32'h0000_1000, 32'h0,         1'b1, 4'h0, 11'd17, 32'h0,         1'b1);
    d1(32'h8001_0000, 32'h1234_5678, 1'b0, 4'hF, 11'd18, 32'h0,         1'b1);
    d1(32'h8000_0000, 32'h0,         1'b1, 4'h0, 11'd19, 32'hCAFE_F00D, 1'b0);

    f1(32'h8000_0010, 64'h1122_AA44_DEAD_BEEF, 1'b0);
    f1(32'h8000_0014, 64'h1122_AA44_DEAD_BEEF, 1'b0);
    f1(32'h7FFF_FFF8, 64'h0,                   1'b1);

    // same-cycle fetch sees pre-write RAM; queued read unaffected by a later write
    fork
      d1(32'h8000_0018, 32'h0000_0099, 1'b0, 4'hF, 11'd20, 32'h0, 1'b0);
      f1(32'h8000_0018, 64'h0BAD_C0DE_0000_0055, 1'b0);
    join
    d1(32'h8000_0018, 32'h0,         1'b1, 4'h0, 11'd21, 32'h0000_0099, 1'b0);
    d1(32'h8000_0018, 32'h0000_0077, 1'b0, 4'hF, 11'd22, 32'h0,         1'b0);
    d1(32'h8000_0018, 32'h0,         1'b1, 4'h0, 11'd23, 32'h0000_0077, 1'b0);
    drain();

    // flush next cycle, then flush together with a fetch
    seen = ivalid_seen;
    bus1.imem_pc = 32'h8000_0000; bus1.imem_rd = 1'b1;
    @(negedge clk);
    chk("flush_fetch_accept", 64'(bus1.imem_accept), 64'd1);
    @(posedge clk); #1;
    bus1.imem_rd = 1'b0; bus1.imem_flush = 1'b1;
    @(posedge clk); #1;
    bus1.imem_rd = 1'b1;
    @(posedge clk); #1;
    bus1.imem_rd = 1'b0; bus1.imem_flush = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_no_valid", 64'(ivalid_seen - seen), 64'd0);
    f1(32'h8000_0000, 64'h0102_0304_CAFE_F00D, 1'b0);
    drain();

    // MMIO interrupt register
    chk("intr_before", 64'(bus1.intr_o), 64'd0);
    d1(INTR, 32'h1, 1'b0, 4'h1, 11'd24, 32'h0, 1'b0);
    chk("intr_set",    64'(bus1.intr_o), 64'd1);
    d1(INTR, 32'h0, 1'b1, 4'h0, 11'd25, 32'h1, 1'b0);
    d1(INTR, 32'h0, 1'b0, 4'h2, 11'd26, 32'h0, 1'b0);
    chk("intr_byte1_ignored", 64'(bus1.intr_o), 64'd1);
    d1(INTR, 32'h0, 1'b0, 4'h1, 11'd27, 32'h0, 1'b0);
    chk("intr_clear",  64'(bus1.intr_o), 64'd0);
    d1(INTR, 32'h0, 1'b1, 4'h0, 11'd28, 32'h0, 1'b0);
    d1(INTR, 32'h1, 1'b0, 4'h1, 11'd29, 32'h0, 1'b0);
    chk("intr_set_again", 64'(bus1.intr_o), 64'd1);
    drain();

    // queue-full backpressure on the long-latency instance (depth 4, latency 6)
    exp_acc = 8'b1100_1111;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      bus2.dmem_rd = (idx < 6);
      bus2.dmem_addr = 32'(idx * 4);
      bus2.dmem_req_tag = 11'(11'h100 + idx);
      @(negedge clk);
      chk("d2_accept", 64'(bus2.dmem_accept), 64'(exp_acc[k]));
      if (bus2.dmem_accept && bus2.dmem_rd) begin
        e.tag = bus2.dmem_req_tag; e.rdata = 32'h0; e.err = 1'b1; e.cyc = cyc + 6;
        dq2.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
    end
    bus2.dmem_rd = 1'b0;
    chk("d2_issued", 64'(idx), 64'd6);
    drain();

    // reset with three requests in flight
    for (int k = 0; k < 3; k++) begin
      bus2.dmem_rd = 1'b1;
      bus2.dmem_addr = 32'h40 + 32'(k * 4);
      bus2.dmem_req_tag = 11'(11'h200 + k);
      @(negedge clk);
      if (bus2.dmem_accept) begin
        e.tag = bus2.dmem_req_tag; e.rdata = 32'h0; e.err = 1'b1; e.cyc = cyc + 6;
        dq2.push_back(e);
      end
      @(posedge clk); #1;
    end
    bus2.dmem_rd = 1'b0;
    chk("pre_rst_inflight", 64'(dq2.size()), 64'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_d1_accept", 64'(bus1.dmem_accept), 64'd0);
    chk("mid_rst_d2_accept", 64'(bus2.dmem_accept), 64'd0);
    chk("mid_rst_d2_ack",    64'(bus2.dmem_ack),    64'd0);
    chk("mid_rst_intr",      64'(bus1.intr_o),      64'd0);
    dq2.delete();
    seen = dack2_seen;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_stale_acks", 64'(dack2_seen - seen), 64'd0);
    chk("post_rst2_accept", 64'(bus2.dmem_accept), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=%0t required<100000", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
